// File: rtl/l2s_stream_sequencer.sv
// ---------------------------------------------------------------------------
// l2s_stream_sequencer
//   AXI-Stream master sequencer for the AXI-Lite to AXI-Stream adapter.
//   A start pulse snapshots up to four data words. The words are then sent
//   as a single packet, with TLAST asserted on the final beat. The block
//   reports busy, a one-cycle done pulse, and a packet counter that wraps.
//
// Ports
//   M_AXIS_ACLK     : clock; all logic updates on the rising edge
//   M_AXIS_ARESETN  : asynchronous reset, active low
//   data0..data3    : payload words; beat k carries datak
//   start           : one-cycle request pulse
//   word            : packet length in beats (0 = no transfer, >4 clamps to 4)
//   busy            : high while a packet is latched or in flight
//   done            : one-cycle pulse after the last beat handshake
//   pkt_count       : number of completed packets, wraps
//   M_AXIS_TDATA    : stream data
//   M_AXIS_TVALID   : stream valid
//   M_AXIS_TREADY   : stream ready from downstream
//   M_AXIS_TLAST    : final beat marker
// ---------------------------------------------------------------------------
module l2s_stream_sequencer #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_PKT_CNT_WIDTH      = 16
) (
  input  logic                            M_AXIS_ACLK,
  input  logic                            M_AXIS_ARESETN,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0] data0,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0] data1,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0] data2,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0] data3,
  input  logic                            start,
  input  logic [2:0]                      word,
  output logic                            busy,
  output logic                            done,
  output logic [C_PKT_CNT_WIDTH-1:0]      pkt_count,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY,
  output logic                            M_AXIS_TLAST
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [C_PKT_CNT_WIDTH-1:0] PktOne = 1;

  state_t                                   state_q, state_d;
  logic [3:0][C_M_AXIS_TDATA_WIDTH-1:0]     snap_q, snap_d;
  logic [2:0]                               len_q, len_d;
  logic [1:0]                               beatIdx_q, beatIdx_d;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]          tdata_q, tdata_d;
  logic                                     tvalid_q, tvalid_d;
  logic                                     tlast_q, tlast_d;
  logic                                     busy_q, busy_d;
  logic                                     done_q, done_d;
  logic [C_PKT_CNT_WIDTH-1:0]               pktCount_q, pktCount_d;

  logic [2:0] wordClamped;
  logic [2:0] lenM1;
  logic [1:0] beatNext;

  assign wordClamped = (word > 3'd4) ? 3'd4 : word;
  assign lenM1       = len_q - 3'd1;
  assign beatNext    = beatIdx_q + 2'd1;

  // Every output comes straight from a register. TLAST and TDATA for the
  // next beat are therefore computed one cycle ahead, and TVALID never sees
  // TREADY combinationally.
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    len_d      = len_q;
    beatIdx_d  = beatIdx_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pktCount_d = pktCount_q;

    case (state_q)
      ST_IDLE: begin
        if (start && (word != 3'd0)) begin
          snap_d    = {data3, data2, data1, data0};
          len_d     = wordClamped;
          beatIdx_d = 2'd0;
          tdata_d   = data0;
          tvalid_d  = 1'b1;
          tlast_d   = (wordClamped == 3'd1);
          busy_d    = 1'b1;
          state_d   = ST_SEND;
        end
      end

      ST_SEND: begin
        if (M_AXIS_TREADY) begin
          if ({1'b0, beatIdx_q} == lenM1) begin
            tvalid_d   = 1'b0;
            tlast_d    = 1'b0;
            done_d     = 1'b1;
            pktCount_d = pktCount_q + PktOne;
            state_d    = ST_DONE;
          end else begin
            beatIdx_d = beatNext;
            tdata_d   = snap_q[beatNext];
            tlast_d   = ({1'b0, beatNext} == lenM1);
          end
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_q    <= ST_IDLE;
      snap_q     <= '0;
      len_q      <= 3'd0;
      beatIdx_q  <= 2'd0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pktCount_q <= '0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      len_q      <= len_d;
      beatIdx_q  <= beatIdx_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pktCount_q <= pktCount_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pkt_count     = pktCount_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TLAST  = tlast_q;

endmodule

// File: tb/tb_l2s_stream_sequencer.sv
// ---------------------------------------------------------------------------
// tb_l2s_stream_sequencer
//   Drives randomized packets into l2s_stream_sequencer and checks them
//   against a transaction-level model. The model holds each packet as a list
//   of expected words, tracks a completed-packet count, and counts accepted
//   beats. A narrow packet counter keeps the wrap test short.
// ---------------------------------------------------------------------------
module tb_l2s_stream_sequencer;

  localparam int DW = 32;
  localparam int CW = 8;

  logic          aclk;
  logic          aresetn;
  logic [DW-1:0] data0, data1, data2, data3;
  logic          start;
  logic [2:0]    word;
  logic          busy, done;
  logic [CW-1:0] pktCount;
  logic [DW-1:0] tdata;
  logic          tvalid, tready, tlast;

  int            vectors;
  int            miscompares;
  logic [CW-1:0] expPkt;

  l2s_stream_sequencer #(
    .C_M_AXIS_TDATA_WIDTH(DW),
    .C_PKT_CNT_WIDTH     (CW)
  ) dut (
    .M_AXIS_ACLK   (aclk),
    .M_AXIS_ARESETN(aresetn),
    .data0         (data0),
    .data1         (data1),
    .data2         (data2),
    .data3         (data3),
    .start         (start),
    .word          (word),
    .busy          (busy),
    .done          (done),
    .pkt_count     (pktCount),
    .M_AXIS_TDATA  (tdata),
    .M_AXIS_TVALID (tvalid),
    .M_AXIS_TREADY (tready),
    .M_AXIS_TLAST  (tlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Hard stop if anything runs away.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Sends one packet and scoreboards it. The task is entered at a falling
  // edge with the DUT idle, and it returns at the falling edge of the first
  // idle cycle after the packet. Inputs are driven and outputs sampled on
  // falling edges. A handshake occurs at the next rising edge whenever the
  // sampled TVALID and the TREADY driven now are both high.
  task automatic run_packet(input logic [2:0] w, input int readyPct,
                            input bit midStart, input string tag);
    logic [DW-1:0] expWords [4];
    int n;
    int idx;
    int cycles;
    n = (w == 3'd0) ? 0 : ((w > 3'd4) ? 4 : int'(w));
    for (int k = 0; k < 4; k++) expWords[k] = $urandom;
    data0  = expWords[0];
    data1  = expWords[1];
    data2  = expWords[2];
    data3  = expWords[3];
    word   = w;
    start  = 1'b1;
    tready = 1'b0;
    @(negedge aclk);
    start = 1'b0;
    data0 = $urandom; data1 = $urandom; data2 = $urandom; data3 = $urandom;
    word  = 3'($urandom_range(0, 7));

    if (n == 0) begin
      repeat (3) begin
        vectors++;
        if (tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pktCount !== expPkt) begin
          miscompares++;
          $display("[TB] FAIL %s zero-len idle: tvalid=%b busy=%b done=%b pkt=%0d, want 0 0 0 pkt=%0d",
                   tag, tvalid, busy, done, pktCount, expPkt);
        end
        @(negedge aclk);
      end
      return;
    end

    idx = 0;
    cycles = 0;
    while (idx < n && cycles < 400) begin
      vectors++;
      if (tvalid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL %s beat%0d ctrl: tvalid=%b busy=%b done=%b, want 1 1 0",
                 tag, idx, tvalid, busy, done);
      end
      vectors++;
      if (tdata !== expWords[idx]) begin
        miscompares++;
        $display("[TB] FAIL %s beat%0d tdata: got %h want %h", tag, idx, tdata, expWords[idx]);
      end
      vectors++;
      if (tlast !== 1'(idx == n - 1)) begin
        miscompares++;
        $display("[TB] FAIL %s beat%0d tlast: got %b want %b", tag, idx, tlast, (idx == n - 1));
      end
      start = midStart && (idx == 1);
      if (start) begin
        data0 = $urandom; data1 = $urandom; data2 = $urandom; data3 = $urandom;
        word  = 3'd4;
      end
      tready = ($urandom_range(0, 99) < readyPct);
      if (tready) idx++;
      @(negedge aclk);
      cycles++;
    end
    start = 1'b0;
    if (idx < n) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s timeout: got %0d beats want %0d", tag, idx, n);
      return;
    end

    expPkt = expPkt + 1'b1;
    tready = 1'($urandom_range(0, 1));
    vectors++;
    if (done !== 1'b1 || busy !== 1'b1 || tvalid !== 1'b0 || tlast !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s done-cycle: done=%b busy=%b tvalid=%b tlast=%b, want 1 1 0 0",
               tag, done, busy, tvalid, tlast);
    end
    vectors++;
    if (pktCount !== expPkt) begin
      miscompares++;
      $display("[TB] FAIL %s pkt_count: got %0d want %0d", tag, pktCount, expPkt);
    end
    @(negedge aclk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || tvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s idle-after: done=%b busy=%b tvalid=%b, want 0 0 0",
               tag, done, busy, tvalid);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    start   = 1'b0;
    word    = 3'd0;
    tready  = 1'b0;
    data0 = '0; data1 = '0; data2 = '0; data3 = '0;
    expPkt = '0;
    #1;
    vectors++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset ctrl: tvalid=%b tlast=%b busy=%b done=%b, want all 0",
               tvalid, tlast, busy, done);
    end
    vectors++;
    if (tdata !== '0 || pktCount !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset data: tdata=%h pkt=%0d, want 0 0", tdata, pktCount);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_full_rate();
    run_packet(3'd4, 100, 1'b0, "full_rate");
    run_packet(3'd1, 100, 1'b0, "single_beat");
  endtask

  task automatic test_stall();
    run_packet(3'd2, 50, 1'b0, "stall2");
    run_packet(3'd4, 35, 1'b0, "stall4");
  endtask

  task automatic test_zero_and_clamp();
    run_packet(3'd0, 100, 1'b0, "word0");
    run_packet(3'd7, 100, 1'b0, "word7");
    run_packet(3'd5, 60, 1'b0, "word5");
  endtask

  task automatic test_start_ignored();
    run_packet(3'd4, 40, 1'b1, "start_ignored");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) run_packet(3'(i + 1), 100, 1'b0, "back_to_back");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      run_packet(3'($urandom_range(0, 7)), $urandom_range(30, 100), 1'($urandom_range(0, 1)), "random");
  endtask

  task automatic test_reset_mid_packet();
    logic [DW-1:0] d0, d1;
    d0 = $urandom;
    d1 = $urandom;
    data0 = d0; data1 = d1; data2 = $urandom; data3 = $urandom;
    word = 3'd4;
    start = 1'b1;
    tready = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    vectors++;
    if (tvalid !== 1'b1 || tdata !== d0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid beat0: tvalid=%b tdata=%h, want 1 %h", tvalid, tdata, d0);
    end
    @(negedge aclk);
    vectors++;
    if (tvalid !== 1'b1 || tdata !== d1) begin
      miscompares++;
      $display("[TB] FAIL rst_mid beat1: tvalid=%b tdata=%h, want 1 %h", tvalid, tdata, d1);
    end
    aresetn = 1'b0;
    #1;
    expPkt = '0;
    vectors++;
    if (tvalid !== 1'b0 || busy !== 1'b0 || tlast !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid abort: tvalid=%b busy=%b tlast=%b done=%b, want all 0",
               tvalid, busy, tlast, done);
    end
    vectors++;
    if (pktCount !== expPkt) begin
      miscompares++;
      $display("[TB] FAIL rst_mid pkt_count: got %0d want %0d", pktCount, expPkt);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    tready = 1'b0;
    @(negedge aclk);
    vectors++;
    if (tvalid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid after release: tvalid=%b busy=%b, want 0 0", tvalid, busy);
    end
    run_packet(3'd1, 100, 1'b0, "post_reset");
  endtask

  task automatic test_wrap();
    int guard;
    guard = 0;
    while (expPkt != {CW{1'b1}} && guard < 400) begin
      run_packet(3'd1, 100, 1'b0, "preload");
      guard++;
    end
    run_packet(3'd1, 100, 1'b0, "wrap");
    vectors++;
    if (pktCount !== '0) begin
      miscompares++;
      $display("[TB] FAIL wrap: pkt_count got %0d want 0", pktCount);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_full_rate();
    test_stall();
    test_zero_and_clamp();
    test_start_ignored();
    test_back_to_back();
    test_random();
    test_reset_mid_packet();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
